// File: rtl/mem_port_arbiter_if.sv
// Requester/RAM bundle shared by the fetch path, the load/store path and the RAM.
// The slave modport is the arbiter's view; the master modport is the requesters' and RAM's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_rdata;
  logic              ls_ack;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_w_en;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
    output if_rdata, if_ack, ls_rdata, ls_ack, ram_addr, ram_wdata, ram_w_en
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_rdata,
    input  if_rdata, if_ack, ls_rdata, ls_ack, ram_addr, ram_wdata, ram_w_en
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising instruction-fetch and load/store accesses
// onto one single-port RAM with a req/ack handshake and fixed read latency.
module mem_port_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic       GNT_IF   = 1'b0;
  localparam logic       GNT_LS   = 1'b1;
  localparam logic [2:0] LAST_CNT = 3'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_grant;
  logic              r_last_grant;
  logic              r_we;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;

  logic w_any_req;
  logic w_pick_ls;
  logic w_rd_last;
  logic w_ram_w_en;
  logic w_if_ack;
  logic w_ls_ack;
  logic w_busy;

  assign w_any_req = bus.if_req | bus.ls_req;
  // On a tie the side that did not win last time gets the grant.
  assign w_pick_ls = bus.ls_req & (~bus.if_req | (r_last_grant == GNT_IF));
  assign w_rd_last = (r_cnt == LAST_CNT);

  always_comb begin
    w_next     = r_state;
    w_ram_w_en = 1'b0;
    w_if_ack   = 1'b0;
    w_ls_ack   = 1'b0;
    w_busy     = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_any_req) w_next = S_ACCESS;
      end
      S_ACCESS: begin
        w_ram_w_en = r_we;
        w_next     = r_we ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (w_rd_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_if_ack = (r_grant == GNT_IF);
        w_ls_ack = (r_grant == GNT_LS);
        w_next   = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant      <= GNT_IF;
      r_last_grant <= GNT_LS;
      r_we         <= 1'b0;
      r_cnt        <= '0;
      r_ram_addr   <= '0;
      r_ram_wdata  <= '0;
      r_if_rdata   <= '0;
      r_ls_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant      <= w_pick_ls;
            r_last_grant <= w_pick_ls;
            r_we         <= w_pick_ls & bus.ls_we;
            r_ram_addr   <= w_pick_ls ? bus.ls_addr : bus.if_addr;
            if (w_pick_ls) r_ram_wdata <= bus.ls_wdata;
          end
        end
        S_ACCESS: r_cnt <= '0;
        S_WAIT: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_rd_last) begin
            if (r_grant == GNT_LS) r_ls_rdata <= bus.ram_rdata;
            else                   r_if_rdata <= bus.ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_w_en  = w_ram_w_en;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.ls_rdata  = r_ls_rdata;
  assign bus.if_ack    = w_if_ack;
  assign bus.ls_ack    = w_ls_ack;
  assign busy          = w_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RD_LAT=1 and one with
// RD_LAT=3, each attached to a small behavioural RAM model.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  logic busy1;
  logic busy3;
  int   total;
  int   bad;

  logic        pre_en;
  logic [10:0] pre_addr;
  logic [31:0] pre_data;

  mem_port_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus1 ();
  mem_port_arbiter_if #(.ADDR_W(11), .DATA_W(32)) bus3 ();

  mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave), .busy(busy1)
  );
  mem_port_arbiter #(.ADDR_W(11), .DATA_W(32), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: data appears RD_LAT cycles after the address is presented.
  logic [31:0] mem1 [0:2047];
  logic [31:0] mem3 [0:2047];
  logic [31:0] rd1;
  logic [31:0] p3 [0:2];

  always @(posedge clk) begin
    if (pre_en)             mem1[pre_addr] <= pre_data;
    else if (bus1.ram_w_en) mem1[bus1.ram_addr] <= bus1.ram_wdata;
    rd1 <= mem1[bus1.ram_addr];
  end

  always @(posedge clk) begin
    if (pre_en)             mem3[pre_addr] <= pre_data;
    else if (bus3.ram_w_en) mem3[bus3.ram_addr] <= bus3.ram_wdata;
    p3[0] <= mem3[bus3.ram_addr];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end

  assign bus1.ram_rdata = rd1;
  assign bus3.ram_rdata = p3[2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int   k;
    int   last_cyc;
    int   cyc;
    logic got_ls;
    logic got_ack;

    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.ls_req = 0; bus1.ls_we = 0;
    bus1.ls_addr = '0; bus1.ls_wdata = '0;
    bus3.if_req = 0; bus3.if_addr = '0; bus3.ls_req = 0; bus3.ls_we = 0;
    bus3.ls_addr = '0; bus3.ls_wdata = '0;
    #2 rst_n = 1'b0;

    // Preload RAM contents while the arbiters are held in reset.
    tick();
    pre_en = 1'b1; pre_addr = 11'd4; pre_data = 32'hE3A01005;
    tick();
    pre_addr = 11'd2; pre_data = 32'h12345678;
    tick();
    pre_en = 1'b0;

    check("rst_busy",   {31'd0, busy1}, 32'd0);
    check("rst_acks",   {30'd0, bus1.if_ack, bus1.ls_ack}, 32'd0);
    check("rst_wen",    {31'd0, bus1.ram_w_en}, 32'd0);
    check("rst_addr",   {21'd0, bus1.ram_addr}, 32'd0);
    check("rst_wdata",  bus1.ram_wdata, 32'd0);
    check("rst_rdata",  bus1.if_rdata | bus1.ls_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // IF read of addr 4, RD_LAT=1.
    bus1.if_req = 1; bus1.if_addr = 11'd4;
    check("t1_c0_busy", {31'd0, busy1}, 32'd0);
    tick();
    check("t1_c1_addr", {21'd0, bus1.ram_addr}, 32'd4);
    check("t1_c1_busy", {31'd0, busy1}, 32'd1);
    check("t1_c1_ack",  {31'd0, bus1.if_ack}, 32'd0);
    check("t1_c1_wen",  {31'd0, bus1.ram_w_en}, 32'd0);
    tick();
    check("t1_c2_ack",  {31'd0, bus1.if_ack}, 32'd0);
    check("t1_c2_busy", {31'd0, busy1}, 32'd1);
    tick();
    check("t1_c3_ack",   {31'd0, bus1.if_ack}, 32'd1);
    check("t1_c3_busy",  {31'd0, busy1}, 32'd1);
    check("t1_c3_rdata", bus1.if_rdata, 32'hE3A01005);
    bus1.if_req = 0;
    tick();
    check("t1_c4_ack",  {31'd0, bus1.if_ack}, 32'd0);
    check("t1_c4_busy", {31'd0, busy1}, 32'd0);

    // LS write of addr 8, then IF read-back.
    bus1.ls_req = 1; bus1.ls_we = 1; bus1.ls_addr = 11'd8; bus1.ls_wdata = 32'hDEADBEEF;
    tick();
    check("t2_c1_wen",   {31'd0, bus1.ram_w_en}, 32'd1);
    check("t2_c1_addr",  {21'd0, bus1.ram_addr}, 32'd8);
    check("t2_c1_wdata", bus1.ram_wdata, 32'hDEADBEEF);
    check("t2_c1_ack",   {31'd0, bus1.ls_ack}, 32'd0);
    tick();
    check("t2_c2_ack",   {31'd0, bus1.ls_ack}, 32'd1);
    check("t2_c2_wen",   {31'd0, bus1.ram_w_en}, 32'd0);
    bus1.ls_req = 0; bus1.ls_we = 0;
    tick();
    check("t2_c3_ack",   {31'd0, bus1.ls_ack}, 32'd0);
    check("t2_lsrdata",  bus1.ls_rdata, 32'd0);
    bus1.if_req = 1; bus1.if_addr = 11'd8;
    tick(); tick(); tick();
    check("t2_rb_ack",   {31'd0, bus1.if_ack}, 32'd1);
    check("t2_rb_rdata", bus1.if_rdata, 32'hDEADBEEF);
    bus1.if_req = 0;
    tick();

    // Simultaneous requests after reset alternate IF, LS, IF, LS.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus1.if_req = 1; bus1.if_addr = 11'd4;
    bus1.ls_req = 1; bus1.ls_we = 0; bus1.ls_addr = 11'd8;
    cyc = 0;
    last_cyc = 0;
    for (int n = 0; n < 4; n++) begin
      k = 0;
      got_ack = bus1.if_ack | bus1.ls_ack;
      while (!got_ack && k < 12) begin
        tick();
        cyc++;
        k++;
        got_ack = bus1.if_ack | bus1.ls_ack;
      end
      check($sformatf("tie_ack_seen_%0d", n), {31'd0, got_ack}, 32'd1);
      got_ls = bus1.ls_ack;
      check($sformatf("tie_grant_%0d", n), {31'd0, got_ls}, {31'd0, n[0]});
      check($sformatf("tie_one_ack_%0d", n), {31'd0, bus1.if_ack & bus1.ls_ack}, 32'd0);
      if (n > 0) check($sformatf("tie_gap_%0d", n), cyc - last_cyc, 32'd4);
      last_cyc = cyc;
      if (n == 3) begin
        bus1.if_req = 0; bus1.ls_req = 0;
      end
      tick();
      cyc++;
    end
    check("tie_if_rdata", bus1.if_rdata, 32'hE3A01005);
    check("tie_ls_rdata", bus1.ls_rdata, 32'hDEADBEEF);
    check("tie_end_busy", {31'd0, busy1}, 32'd0);

    // RD_LAT=3 LS read of addr 2.
    bus3.ls_req = 1; bus3.ls_we = 0; bus3.ls_addr = 11'd2;
    for (int c = 1; c <= 5; c++) begin
      tick();
      check($sformatf("t4_ack_c%0d", c), {31'd0, bus3.ls_ack}, {31'd0, c == 5});
    end
    check("t4_ls_rdata", bus3.ls_rdata, 32'h12345678);
    check("t4_if_rdata", bus3.if_rdata, 32'd0);
    bus3.ls_req = 0;
    tick();
    check("t4_c6_ack", {31'd0, bus3.ls_ack}, 32'd0);

    // Asynchronous reset during the WAIT cycle of an IF read.
    bus1.if_req = 1; bus1.if_addr = 11'd4;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t5_busy",   {31'd0, busy1}, 32'd0);
    check("t5_acks",   {30'd0, bus1.if_ack, bus1.ls_ack}, 32'd0);
    check("t5_addr",   {21'd0, bus1.ram_addr}, 32'd0);
    check("t5_rdata",  bus1.if_rdata | bus1.ls_rdata, 32'd0);
    check("t5_wdata",  bus1.ram_wdata, 32'd0);
    bus1.if_req = 0;
    tick();
    rst_n = 1'b1;
    got_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      got_ack = got_ack | bus1.if_ack;
    end
    check("t5_no_ack", {31'd0, got_ack}, 32'd0);
    bus1.if_req = 1; bus1.if_addr = 11'd8;
    tick(); tick(); tick();
    check("t5_next_ack",   {31'd0, bus1.if_ack}, 32'd1);
    check("t5_next_rdata", bus1.if_rdata, 32'hDEADBEEF);
    bus1.if_req = 0;
    tick();

    // IF request withdrawn in cycle 1 still completes.
    bus1.if_req = 1; bus1.if_addr = 11'd4;
    tick();
    bus1.if_req = 0;
    tick();
    tick();
    check("t6_ack",   {31'd0, bus1.if_ack}, 32'd1);
    check("t6_rdata", bus1.if_rdata, 32'hE3A01005);
    tick();
    check("t6_c4_busy", {31'd0, busy1}, 32'd0);
    tick();
    check("t6_c5_busy", {31'd0, busy1}, 32'd0);
    check("t6_c5_ack",  {31'd0, bus1.if_ack}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
